// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way priority arbiter for one single-port synchronous RAM
module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    tag_q, tag_d;
  logic          rd_valid_q, rd_valid_d;
  logic          promote;

  assign promote = (starve_cnt_q == SW'(STARVE_MAX));

  // Grants are qualified by rst so everything reads zero while reset is held.
  always_comb begin
    ld_gnt = rst & ld_req;
    if_gnt = rst & ~ld_req & if_req & (promote | ~dm_req);
    dm_gnt = rst & ~ld_req & dm_req & ~(promote & if_req);
  end

  always_comb begin
    mem_addr = addr_q;
    mem_in   = '0;
    mem_we   = 1'b0;
    if (ld_gnt) begin
      mem_addr = ld_addr;
      mem_in   = ld_wdata;
      mem_we   = ld_we;
    end else if (dm_gnt) begin
      mem_addr = dm_addr;
      mem_in   = dm_wdata;
      mem_we   = dm_we;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    addr_d       = mem_addr;
    tag_d        = {ld_gnt & ~ld_we, dm_gnt & ~dm_we, if_gnt};
    rd_valid_d   = |tag_d;
    starve_cnt_d = starve_cnt_q;
    // Loader-held cycles freeze the counter so the loader cannot reset fetch's claim.
    if (!ld_req) begin
      if (!if_req || if_gnt) begin
        starve_cnt_d = '0;
      end else if (!promote) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      addr_q       <= '0;
      tag_q        <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign ld_rvalid = rd_valid_q & tag_q[2];
  assign dm_rvalid = rd_valid_q & tag_q[1];
  assign if_rvalid = rd_valid_q & tag_q[0];
  assign ld_rdata  = ld_rvalid ? mem_out : '0;
  assign dm_rdata  = dm_rvalid ? mem_out : '0;
  assign if_rdata  = if_rvalid ? mem_out : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a RAM and priority model
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ld_req = 0, ld_we = 0, dm_req = 0, dm_we = 0, if_req = 0;
  logic [AW-1:0] ld_addr = '0, dm_addr = '0, if_addr = '0;
  logic [DW-1:0] ld_wdata = '0, dm_wdata = '0;
  logic ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid, mem_we;
  logic [DW-1:0] ld_rdata, dm_rdata, if_rdata, mem_in;
  logic [DW-1:0] mem_out = '0;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_in;
    mem_out <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int owner; logic [DW-1:0] data; } rd_t;
  rd_t rq[$];

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] shadow [int];
  int starve = 0;
  logic [AW-1:0] last_addr = '0;
  bit kill = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: fixed priority ld > (starved fetch) > dm > fetch, with a
  // count of consecutive non-loader cycles in which fetch asked and lost.
  task automatic model_check(output logic [2:0] g);
    logic eld, edm, eif, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ein;
    int ow;
    eld = rst && ld_req;
    eif = rst && !ld_req && if_req && (starve >= SMAX || !dm_req);
    edm = rst && !ld_req && dm_req && !eif;
    g = {ld_gnt, dm_gnt, if_gnt};
    chk("gnt", 32'(g), 32'({eld, edm, eif}));
    ea = last_addr; ewe = 0; ein = '0; ow = -1;
    if (eld)      begin ea = ld_addr; ewe = ld_we; ein = ld_wdata; ow = 0; end
    else if (edm) begin ea = dm_addr; ewe = dm_we; ein = dm_wdata; ow = 1; end
    else if (eif) begin ea = if_addr; ow = 2; end
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_in", mem_in, ein);
    if (ow >= 0) begin
      last_addr = ea;
      if (ewe) shadow[int'(ea)] = ein;
      else if (!kill) rq.push_back('{cyc: cyc, owner: ow,
                                     data: shadow.exists(int'(ea)) ? shadow[int'(ea)] : '0});
    end
    if (!rst) starve = 0;
    else if (!ld_req) begin
      if (!if_req || eif) starve = 0;
      else if (starve < SMAX) starve++;
    end
  endtask

  // Monitor: each cycle, a return is due iff the oldest queued read was granted last cycle.
  always @(posedge clk) begin
    logic [2:0] erv;
    logic [DW-1:0] ed;
    #2;
    erv = 3'b000; ed = '0;
    if (rq.size() > 0 && rq[0].cyc == cyc - 1) begin
      erv = 3'b100 >> rq[0].owner;
      ed  = rq[0].data;
      void'(rq.pop_front());
    end
    if (erv != 3'b000 || {ld_rvalid, dm_rvalid, if_rvalid} != 3'b000) begin
      chk("rvalid", 32'({ld_rvalid, dm_rvalid, if_rvalid}), 32'(erv));
      chk("ld_rdata", ld_rdata, erv[2] ? ed : '0);
      chk("dm_rdata", dm_rdata, erv[1] ? ed : '0);
      chk("if_rdata", if_rdata, erv[0] ? ed : '0);
    end else if (!rst) begin
      chk("rst_rdata", ld_rdata | dm_rdata | if_rdata, '0);
    end
  end

  task automatic run(output logic [2:0] g);
    @(negedge clk);
    model_check(g);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_req = 0; ld_we = 0; dm_req = 0; dm_we = 0; if_req = 0;
    ld_wdata = '0; dm_wdata = '0;
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic [2:0] g);
    idle(); ld_req = 1; ld_we = 1; ld_addr = a; ld_wdata = d;
    run(g);
  endtask

  logic [2:0] g;
  logic [2:0] starve_pat [6];

  initial begin
    starve_pat[0] = 3'b010; starve_pat[1] = 3'b010; starve_pat[2] = 3'b010;
    starve_pat[3] = 3'b010; starve_pat[4] = 3'b001; starve_pat[5] = 3'b010;
    @(posedge clk); #1;
    dm_req = 1; if_req = 1; ld_req = 1;
    run(g); run(g);
    rst = 1; idle();
    for (int i = 0; i < 16; i++) ld_write(AW'(i), $urandom, g);
    ld_write(12'h004, 32'h2402000A, g);
    ld_write(12'h100, 32'hDEADBEEF, g);
    idle(); run(g);

    // reset mid-read
    idle(); dm_req = 1; dm_addr = 12'h010; kill = 1;
    run(g);
    kill = 0; rst = 0; last_addr = '0; starve = 0;
    for (int i = 0; i < 3; i++) run(g);
    rst = 1; idle();

    // single fetch, the first cycle out of reset
    if_req = 1; if_addr = 12'h004;
    run(g);
    chk("fetch_gnt", 32'(g), 32'(3'b001));
    idle(); run(g);

    // dm vs fetch contention
    dm_req = 1; dm_addr = 12'h100; if_req = 1; if_addr = 12'h005;
    run(g);
    chk("contend_gnt0", 32'(g), 32'(3'b010));
    dm_req = 0;
    run(g);
    chk("contend_gnt1", 32'(g), 32'(3'b001));

    // starvation guard under continuous dm traffic
    dm_req = 1; dm_addr = 12'h006; if_req = 1; if_addr = 12'h007;
    for (int i = 0; i < 6; i++) begin
      run(g);
      chk("starve_seq", 32'(g), 32'(starve_pat[i]));
    end

    // loader lock with dm/fetch held
    for (int i = 0; i < 8; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = AW'(i); ld_wdata = 32'(i + 1);
      run(g);
      chk("ld_lock", 32'(g), 32'(3'b100));
    end
    idle(); if_req = 1; if_addr = 12'h003;
    run(g);
    idle(); run(g);

    // dm write produces no return, readback follows
    dm_req = 1; dm_we = 1; dm_addr = 12'h020; dm_wdata = 32'h12345678;
    run(g);
    dm_we = 0;
    run(g);
    idle(); run(g);

    // randomized traffic over a small address window to exercise hazards
    for (int n = 0; n < 1500; n++) begin
      ld_req   = ($urandom_range(0, 7) == 0);
      ld_we    = $urandom_range(0, 1) == 1;
      ld_addr  = AW'($urandom_range(0, 15));
      ld_wdata = $urandom;
      dm_req   = ($urandom_range(0, 3) != 0);
      dm_we    = $urandom_range(0, 2) == 0;
      dm_addr  = AW'($urandom_range(0, 15));
      dm_wdata = $urandom;
      if_req   = ($urandom_range(0, 3) != 0);
      if_addr  = AW'($urandom_range(0, 15));
      if (n == 700) begin
        run(g);
        rst = 0; last_addr = '0; starve = 0; rq.delete();
        idle(); run(g);
        rst = 1;
      end else begin
        run(g);
      end
    end
    idle();
    for (int i = 0; i < 3; i++) run(g);
    chk("queue_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word RAM (1-cycle read latency) between three requesters.
- Requesters, highest priority first: program loader (ld), processor data stage (dm), processor instruction fetch (if).
- Lets the pipeline run from a unified memory, and lets a host loader write code while the core is held off.
- A starvation guard guarantees fetch forward progress under back-to-back data traffic.

Parameters:
AW, 12, word address width (4096 words)
DW, 32, data width
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is promoted over dm (min 1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
ld_req  in  1  loader request
ld_we  in  1  loader write enable (1 = write)
ld_addr  in  AW  loader word address
ld_wdata  in  DW  loader write data
ld_gnt  out  1  loader granted this cycle
dm_req  in  1  data request
dm_we  in  1  data write enable
dm_addr  in  AW  data word address
dm_wdata  in  DW  data write data
dm_gnt  out  1  data granted this cycle
dm_rvalid  out  1  data read result valid
dm_rdata  out  DW  data read result
if_req  in  1  fetch request (read only)
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch granted this cycle
if_rvalid  out  1  fetch read result valid
if_rdata  out  DW  fetch read result
ld_rvalid  out  1  loader read result valid (readback)
ld_rdata  out  DW  loader read result
mem_addr  out  AW  RAM address
mem_in  out  DW  RAM write data
mem_we  out  1  RAM write enable
mem_out  in  DW  RAM read data, valid the cycle after the address is presented

Behaviour:
- Grants are combinational from the current requests and the registered starvation state. At most one gnt is high per cycle.
- Priority:
  - ld_req wins unconditionally.
  - Otherwise, if promote=1 and if_req, fetch wins.
  - Otherwise dm_req wins, else if_req.
- Memory drive:
  - mem_addr and mem_in are muxed from the granted requester.
  - mem_we = granted requester's we (always 0 for fetch).
  - With no grant: mem_we=0, mem_addr holds its last granted value (registered hold), mem_in=0.
- Read return:
  - A granted read registers owner tag {ld,dm,if} plus a valid bit.
  - Next cycle exactly one of ld/dm/if_rvalid pulses for 1 cycle, and its rdata = mem_out.
  - Writes produce no rvalid.
  - rdata outputs are mem_out gated to 0 when the matching rvalid is 0.
- Starvation counter:
  - starve_cnt, width clog2(STARVE_MAX+1), reset 0.
  - Increments when if_req && !if_gnt && !ld_req.
  - Clears on if_gnt or !if_req.
  - Saturates at STARVE_MAX.
  - promote = (starve_cnt == STARVE_MAX), registered value.
  - Loader-held cycles neither increment nor clear the counter (it holds).
- Loader lock: while ld_req is high, dm and if are never granted. Requesters must hold req/addr/wdata stable until gnt; a dropped req is simply not served.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent (full pipelining; one access per cycle).
  - A read's rvalid is delivered even if the owner dropped req.
- Reset (rst=0, any time, including mid-read):
  - all gnt=0, all rvalid=0, all rdata=0, mem_we=0, mem_addr=0, mem_in=0.
  - Owner tag and valid bit cleared; starve_cnt=0.
  - A read granted in the cycle reset asserts returns no rvalid.
  - First grant possible in the first cycle after rst rises.
- Hazard note: a dm write followed by an if read of the same address in the next cycle returns the new data (RAM write-before-read order is the RAM's responsibility; the arbiter adds no bypass).

Test Plan:
- Reset mid-read: dm read to 0x010 granted, rst=0 in the following cycle → no dm_rvalid; all outputs 0 throughout reset.
- Single fetch: if_req, if_addr=0x004, RAM[4]=0x2402000A → if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x2402000A, dm_rvalid=0.
- dm vs if contention: dm_req and if_req both high for 1 cycle, dm read 0x100 (RAM=0xDEADBEEF) → dm_gnt=1, if_gnt=0. Next cycle dm_rvalid with 0xDEADBEEF and if_gnt=1.
- Starvation with STARVE_MAX=4: dm_req and if_req held high continuously → dm_gnt for 4 cycles, fetch granted on the 5th cycle, counter back to 0, dm regains the grant on the 6th.
- Loader lock: ld writes 0x00000001..0x00000008 to 0x000..0x007 over 8 cycles while dm_req and if_req are held → only ld_gnt; starve_cnt unchanged. Fetch of 0x003 afterwards returns 0x00000004.
- Write no-return: dm_we=1, dm_addr=0x020, dm_wdata=0x12345678 → mem_we=1 for one cycle, no rvalid. A dm read of 0x020 next returns 0x12345678.
